fft_input_streamer: RTL and testbench

FFT_INPUT_STREAMER -- requirements
Module: fft_input_streamer

---
 rtl/fft_input_streamer.sv | 172 +++++++++++++++++
 tb/tb_fft_input_streamer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_input_streamer.sv
// ADC-to-FFT sample streamer.
// Buffers samples and paces them out, one per gap window.
module fft_input_streamer #(
  parameter int FFT_LENGTH = 1024,
  parameter int SAMPLE_GAP = 20,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start_i,
  input  logic [11:0]                  adc_data_i,
  input  logic                         adc_valid_i,
  input  logic                         done_FFT_i,
  output logic [15:0]                  input_real_o,
  output logic [15:0]                  input_imaginary_o,
  output logic                         input_stream_active_o,
  output logic                         fft_reset_o,
  output logic                         busy_o,
  output logic                         overflow_o,
  output logic [$clog2(FFT_LENGTH):0]  sample_count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = $clog2(SAMPLE_GAP + 2);
  localparam int CW = $clog2(FFT_LENGTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    WAIT_DONE,
    RESTART
  } state_t;

  state_t        state_q, state_d;
  logic [AW:0]   wr_q, wr_d;
  logic [AW:0]   rd_q, rd_d;
  logic [11:0]   mem_q [FIFO_DEPTH];
  logic [GW-1:0] gap_q, gap_d;
  logic [15:0]   real_q, real_d;
  logic          act_q, act_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic empty;
  logic full;
  logic run;
  logic pop;
  logic push_req;
  logic push;
  logic last;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);

  // Push/pop only while streaming and still enabled;
  // a full FIFO takes a push only if it pops too.
  assign run      = (state_q == STREAM) && start_i;
  assign pop      = run && !empty && (gap_q == '0);
  assign push_req = run && adc_valid_i;
  assign push     = push_req && (!full || pop);
  assign last     = pop && (cnt_q == CW'(FFT_LENGTH - 1));

  // Next-state and datapath updates
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    gap_d   = (gap_q != '0) ? gap_q - 1'b1 : '0;
    real_d  = real_q;
    act_d   = 1'b0;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;

    if (push) wr_d = wr_q + 1'b1;
    if (push_req && !push) ovf_d = 1'b1;

    if (pop) begin
      rd_d   = rd_q + 1'b1;
      real_d = {mem_q[rd_q[AW-1:0]], 4'b0000};
      act_d  = 1'b1;
      gap_d  = GW'(SAMPLE_GAP);
      cnt_d  = cnt_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        wr_d  = '0;
        rd_d  = '0;
        gap_d = '0;
        cnt_d = '0;
        if (start_i) begin
          state_d = STREAM;
          ovf_d   = 1'b0;
        end
      end
      STREAM: begin
        if (!start_i) begin
          state_d = IDLE;
          wr_d    = '0;
          rd_d    = '0;
          gap_d   = '0;
          cnt_d   = '0;
          real_d  = '0;
        end else if (last) begin
          state_d = WAIT_DONE;
          wr_d    = '0;
          rd_d    = '0;
        end
      end
      WAIT_DONE: begin
        wr_d = '0;
        rd_d = '0;
        if (!start_i) begin
          state_d = IDLE;
          gap_d   = '0;
          cnt_d   = '0;
          real_d  = '0;
        end else if (done_FFT_i) begin
          state_d = RESTART;
          cnt_d   = '0;
        end
      end
      RESTART: begin
        wr_d    = '0;
        rd_d    = '0;
        gap_d   = '0;
        cnt_d   = '0;
        state_d = start_i ? STREAM : IDLE;
      end
    endcase
  end

  // State and control registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      gap_q   <= '0;
      real_q  <= '0;
      act_q   <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      gap_q   <= gap_d;
      real_q  <= real_d;
      act_q   <= act_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sample storage; contents are don't-care while empty
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= adc_data_i;
  end

  assign input_real_o          = real_q;
  assign input_imaginary_o     = '0;
  assign input_stream_active_o = act_q;
  assign overflow_o            = ovf_q;
  assign sample_count_o        = cnt_q;
  assign fft_reset_o = (state_q == IDLE) ||
                       (state_q == RESTART);
  assign busy_o      = (state_q == STREAM) ||
                       (state_q == WAIT_DONE);

endmodule

// File: tb/tb_fft_input_streamer.sv
// Bench for fft_input_streamer.
// Scoreboard of expected samples plus scenario table.
module tb_fft_input_streamer;

  localparam int FL = 1024;
  localparam int SG = 20;
  localparam int FD = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [11:0] adc_data_i;
  logic        adc_valid_i;
  logic        done_FFT_i;
  logic [15:0] input_real_o;
  logic [15:0] input_imaginary_o;
  logic        input_stream_active_o;
  logic        fft_reset_o;
  logic        busy_o;
  logic        overflow_o;
  logic [10:0] sample_count_o;

  fft_input_streamer #(
    .FFT_LENGTH(FL),
    .SAMPLE_GAP(SG),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .start_i              (start_i),
    .adc_data_i           (adc_data_i),
    .adc_valid_i          (adc_valid_i),
    .done_FFT_i           (done_FFT_i),
    .input_real_o         (input_real_o),
    .input_imaginary_o    (input_imaginary_o),
    .input_stream_active_o(input_stream_active_o),
    .fft_reset_o          (fft_reset_o),
    .busy_o               (busy_o),
    .overflow_o           (overflow_o),
    .sample_count_o       (sample_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n;
    int          period;
    logic [11:0] base;
    logic        exp_ovf;
  } row_t;

  int          checks = 0;
  int          errors = 0;
  logic [11:0] exp_q[$];
  int          n_pulse = 0;
  int          n_sp = 0;
  int          since = 1000;
  int          frame_pulses = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [11:0] d,
                      input bit keep);
    adc_data_i  = d;
    adc_valid_i = 1'b1;
    if (keep) exp_q.push_back(d);
    tick();
    adc_valid_i = 1'b0;
  endtask

  task automatic drain(input int limit);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < limit) begin
      tick();
      k++;
    end
    chk("drain", exp_q.size(), 0);
    repeat (SG + 5) tick();
  endtask

  // Output monitor / scoreboard
  always @(negedge clk) begin
    logic [11:0] d;
    if (reset) begin
      since++;
      if (input_stream_active_o) begin
        n_pulse++;
        if (since == SG + 1) n_sp++;
        chk("spacing", since >= SG + 1, 1);
        since = 0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got %0h expected none",
                   input_real_o);
        end else begin
          d = exp_q.pop_front();
          chk("real", input_real_o, {d, 4'b0000});
        end
        frame_pulses++;
        chk("count", sample_count_o, frame_pulses);
        chk("imag", input_imaginary_o, 0);
      end
    end
  end

  row_t rows[3];

  initial begin
    int p0;
    int s0;
    rows[0] = '{n: 16, period: 1,  base: 12'h100, exp_ovf: 1'b0};
    rows[1] = '{n: 5,  period: 21, base: 12'hABC, exp_ovf: 1'b0};
    rows[2] = '{n: 8,  period: 10, base: 12'h7F0, exp_ovf: 1'b0};

    reset = 1'b0;
    start_i = 1'b0;
    adc_data_i = '0;
    adc_valid_i = 1'b0;
    done_FFT_i = 1'b0;
    #3;
    chk("rst_fftrst", fft_reset_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_act", input_stream_active_o, 0);
    chk("rst_real", input_real_o, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_cnt", sample_count_o, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    tick();

    // IDLE ignores samples
    for (int i = 0; i < 5; i++) send(12'hFFF, 0);
    repeat (5) tick();
    chk("idle_busy", busy_o, 0);

    start_i = 1'b1;
    tick();
    chk("strm_busy", busy_o, 1);
    chk("strm_fftrst", fft_reset_o, 0);

    // Table scenarios
    for (int r = 0; r < 3; r++) begin
      p0 = n_pulse;
      s0 = n_sp;
      for (int i = 0; i < rows[r].n; i++) begin
        send(rows[r].base + 12'(i), 1);
        repeat (rows[r].period - 1) tick();
      end
      drain(rows[r].n * 25 + 50);
      chk("row_pulses", n_pulse - p0, rows[r].n);
      chk("row_sp21", n_sp - s0, rows[r].n - 1);
      chk("row_ovf", overflow_o, rows[r].exp_ovf);
    end

    // Latency, then overflow with no pops in flight
    p0 = n_pulse;
    send(12'h5A5, 1);
    chk("lat_t1", input_stream_active_o, 0);
    tick();
    chk("lat_t2", input_stream_active_o, 1);
    chk("lat_real", input_real_o, 16'h5A50);
    for (int i = 0; i < 20; i++)
      send(12'h200 + 12'(i), i < FD);
    chk("ovf_set", overflow_o, 1);
    drain(800);
    chk("ovf_pulses", n_pulse - p0, 17);
    chk("ovf_sticky", overflow_o, 1);

    // Abort then restart clears overflow
    start_i = 1'b0;
    tick();
    chk("ab_fftrst", fft_reset_o, 1);
    chk("ab_busy", busy_o, 0);
    chk("ab_cnt", sample_count_o, 0);
    chk("ab_real", input_real_o, 0);
    frame_pulses = 0;
    start_i = 1'b1;
    tick();
    chk("rs_ovf", overflow_o, 0);

    // Full frame
    for (int i = 0; i < FL; i++) begin
      send(12'(i), 1);
      repeat (SG) tick();
    end
    drain(100);
    chk("fr_cnt", sample_count_o, FL);
    chk("fr_pulses", frame_pulses, FL);
    chk("wd_busy", busy_o, 1);
    chk("wd_fftrst", fft_reset_o, 0);
    for (int i = 0; i < 20; i++) send(12'h3C3, 0);
    repeat (30) tick();
    chk("wd_ovf", overflow_o, 0);
    chk("wd_cnt", sample_count_o, FL);

    // Turnaround
    frame_pulses = 0;
    done_FFT_i = 1'b1;
    tick();
    done_FFT_i = 1'b0;
    chk("rst1_fftrst", fft_reset_o, 1);
    chk("rst1_cnt", sample_count_o, 0);
    tick();
    chk("rst2_fftrst", fft_reset_o, 0);
    chk("rst2_busy", busy_o, 1);
    chk("rst2_cnt", sample_count_o, 0);

    // Abort after 500 samples
    for (int i = 0; i < 500; i++) begin
      send(12'(i * 7), 1);
      repeat (SG) tick();
    end
    drain(100);
    chk("ab5_cnt", sample_count_o, 500);
    p0 = n_pulse;
    start_i = 1'b0;
    tick();
    chk("ab5_fftrst", fft_reset_o, 1);
    chk("ab5_busy", busy_o, 0);
    chk("ab5_cnt0", sample_count_o, 0);
    for (int i = 0; i < 40; i++) send(12'h777, 0);
    repeat (5) tick();
    chk("ab5_nopulse", n_pulse - p0, 0);

    // Asynchronous reset mid-stream
    start_i = 1'b1;
    tick();
    frame_pulses = 0;
    send(12'h123, 1);
    tick();
    chk("ar_pre_act", input_stream_active_o, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_act", input_stream_active_o, 0);
    chk("ar_real", input_real_o, 0);
    chk("ar_fftrst", fft_reset_o, 1);
    chk("ar_busy", busy_o, 0);
    chk("ar_ovf", overflow_o, 0);
    chk("ar_cnt", sample_count_o, 0);
    exp_q.delete();
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk("ar_post_busy", busy_o, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
